irrigation_zone_ctrl: RTL and testbench

Multi-zone successor to the single-zone irrigation FSM. It scans N soil-moisture channels round-robin and opens at most one valve at a time. Watering is gated by a light window. Duration is selected by a two-level dryness threshold, with early stop once the zone is moist and a soak gap after each watering. It sits between the sensor ADC registers and the valve drivers.

---
 rtl/irrigation_zone_ctrl_if.sv | 34 +++
 rtl/irrigation_zone_ctrl.sv | 177 +++++++++++++++++
 tb/tb_irrigation_zone_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_zone_ctrl_if.sv
// Sensor/threshold inputs and valve/status outputs of the multi-zone
// irrigation controller, bundled so the sensor side and the valve side
// share one connection.
interface irrigation_zone_ctrl_if #(
  parameter int ZONES   = 4,
  parameter int SENSE_W = 7,
  parameter int TIME_W  = 7
);
  localparam int ZW = (ZONES > 32'sd1) ? $clog2(ZONES) : 1;

  logic [ZONES*SENSE_W-1:0] m_sense;
  logic [SENSE_W-1:0]       l_sense;
  logic [SENSE_W-1:0]       l_thresh;
  logic [SENSE_W-1:0]       m_thresh_1;
  logic [SENSE_W-1:0]       m_thresh_2;
  logic [TIME_W-1:0]        water_time_in;
  logic [ZONES-1:0]         valve;
  logic                     water_toggle;
  logic [1:0]               state;
  logic [ZW-1:0]            active_zone;
  logic                     zone_done;

  // Sensor/ADC side: drives readings and limits, observes valves and status.
  modport master (
    output m_sense, l_sense, l_thresh, m_thresh_1, m_thresh_2, water_time_in,
    input  valve, water_toggle, state, active_zone, zone_done
  );

  // Controller side.
  modport slave (
    input  m_sense, l_sense, l_thresh, m_thresh_1, m_thresh_2, water_time_in,
    output valve, water_toggle, state, active_zone, zone_done
  );
endinterface

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller. Scans the moisture channels round-robin,
// opens at most one valve at a time while the light window is open, waters
// for one or two base lengths depending on dryness, stops early once the zone
// reads moist, and leaves a soak gap before resuming the scan.
module irrigation_zone_ctrl #(
  parameter int ZONES       = 4,
  parameter int SENSE_W     = 7,
  parameter int TIME_W      = 7,
  parameter int SOAK_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  irrigation_zone_ctrl_if.slave bus
);

  localparam int ZW  = (ZONES > 32'sd1) ? $clog2(ZONES) : 1;
  localparam int TW  = TIME_W + 1;
  localparam int SOW = (SOAK_CYCLES > 32'sd1) ? $clog2(SOAK_CYCLES) : 1;

  localparam logic [ZW-1:0]  LAST_ZONE = ZW'(ZONES - 32'sd1);
  localparam logic [ZW-1:0]  ZONE_ONE  = {{(ZW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]  TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [SOW-1:0] SOAK_ONE  = {{(SOW-1){1'b0}}, 1'b1};
  localparam logic [SOW-1:0] SOAK_LOAD = SOW'(SOAK_CYCLES - 32'sd1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    WATER = 2'b10,
    SOAK  = 2'b11
  } state_t;

  state_t             state_r, next_state_s;
  logic [ZONES-1:0]   valve_r, valve_nxt_s;
  logic               water_toggle_r;
  logic [ZW-1:0]      active_zone_r, zone_nxt_s;
  logic               zone_done_r, zone_done_nxt_s;
  logic [TW-1:0]      timer_r, timer_nxt_s;
  logic [SOW-1:0]     soak_r, soak_nxt_s;

  logic               light_ok_s;
  logic [SENSE_W-1:0] m_cur_s;
  logic [ZONES-1:0]   zone_onehot_s;
  logic [TW-1:0]      dur_single_s;
  logic [TW-1:0]      dur_double_s;

  // Round-robin successor; a single-zone build always stays on zone 0.
  function automatic logic [ZW-1:0] next_zone(input logic [ZW-1:0] z);
    logic [ZW-1:0] r;
    if (z == LAST_ZONE) begin
      r = {ZW{1'b0}};
    end else begin
      r = z + ZONE_ONE;
    end
    return r;
  endfunction

  assign light_ok_s   = (bus.l_sense <= bus.l_thresh);
  assign dur_single_s = {1'b0, bus.water_time_in};
  assign dur_double_s = {bus.water_time_in, 1'b0};

  // Select the reading of the zone under the pointer and its one-hot valve mask.
  always_comb begin
    m_cur_s       = {SENSE_W{1'b0}};
    zone_onehot_s = {ZONES{1'b0}};
    for (int z = 0; z < ZONES; z++) begin
      m_cur_s = m_cur_s |
                ({SENSE_W{active_zone_r == ZW'(z)}} & bus.m_sense[z*SENSE_W +: SENSE_W]);
      zone_onehot_s[z] = (active_zone_r == ZW'(z));
    end
  end

  // Next state and next values of every registered output, timer and soak count.
  always_comb begin
    next_state_s    = state_r;
    zone_nxt_s      = active_zone_r;
    valve_nxt_s     = {ZONES{1'b0}};
    zone_done_nxt_s = 1'b0;
    timer_nxt_s     = timer_r;
    soak_nxt_s      = soak_r;
    case (state_r)
      IDLE: begin
        if (light_ok_s) begin
          next_state_s = SCAN;
        end else begin
          next_state_s = IDLE;
        end
      end
      SCAN: begin
        if (!light_ok_s) begin
          next_state_s = IDLE;
        end else if (bus.water_time_in == {TIME_W{1'b0}}) begin
          zone_nxt_s = next_zone(active_zone_r);
        end else if (m_cur_s < bus.m_thresh_2) begin
          // "Very dry" is tested first so it wins whatever the threshold order.
          next_state_s = WATER;
          valve_nxt_s  = zone_onehot_s;
          timer_nxt_s  = dur_double_s - TIMER_ONE;
        end else if (m_cur_s < bus.m_thresh_1) begin
          next_state_s = WATER;
          valve_nxt_s  = zone_onehot_s;
          timer_nxt_s  = dur_single_s - TIMER_ONE;
        end else begin
          zone_nxt_s = next_zone(active_zone_r);
        end
      end
      WATER: begin
        if (!light_ok_s) begin
          // Abort keeps the pointer so the same zone is rescanned later.
          next_state_s = IDLE;
          timer_nxt_s  = {TW{1'b0}};
        end else if ((m_cur_s >= bus.m_thresh_1) || (timer_r == {TW{1'b0}})) begin
          next_state_s    = SOAK;
          zone_done_nxt_s = 1'b1;
          timer_nxt_s     = {TW{1'b0}};
          soak_nxt_s      = SOAK_LOAD;
        end else begin
          valve_nxt_s = valve_r;
          timer_nxt_s = timer_r - TIMER_ONE;
        end
      end
      SOAK: begin
        if (!light_ok_s) begin
          next_state_s = IDLE;
          zone_nxt_s   = next_zone(active_zone_r);
          soak_nxt_s   = {SOW{1'b0}};
        end else if (soak_r == {SOW{1'b0}}) begin
          next_state_s = SCAN;
          zone_nxt_s   = next_zone(active_zone_r);
        end else begin
          soak_nxt_s = soak_r - SOAK_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        zone_nxt_s   = {ZW{1'b0}};
        timer_nxt_s  = {TW{1'b0}};
        soak_nxt_s   = {SOW{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs, watering timer and soak counter; reset closes valves at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valve_r        <= {ZONES{1'b0}};
      water_toggle_r <= 1'b0;
      active_zone_r  <= {ZW{1'b0}};
      zone_done_r    <= 1'b0;
      timer_r        <= {TW{1'b0}};
      soak_r         <= {SOW{1'b0}};
    end else begin
      valve_r        <= valve_nxt_s;
      water_toggle_r <= |valve_nxt_s;
      active_zone_r  <= zone_nxt_s;
      zone_done_r    <= zone_done_nxt_s;
      timer_r        <= timer_nxt_s;
      soak_r         <= soak_nxt_s;
    end
  end

  assign bus.valve        = valve_r;
  assign bus.water_toggle = water_toggle_r;
  assign bus.state        = state_r;
  assign bus.active_zone  = active_zone_r;
  assign bus.zone_done    = zone_done_r;

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Bench for irrigation_zone_ctrl: a table of scan scenarios plus hand-written
// sequences for early stop, light abort and asynchronous reset. Each expected
// watering (valve mask, on-time) is queued when stimulus is applied and is
// matched against what the valve monitor measures when zone_done pulses.
module tb_irrigation_zone_ctrl;
  localparam int ZONES = 4, SENSE_W = 7, TIME_W = 7, SOAK_CYCLES = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irrigation_zone_ctrl_if #(.ZONES(ZONES), .SENSE_W(SENSE_W), .TIME_W(TIME_W)) bus ();

  irrigation_zone_ctrl #(
    .ZONES(ZONES), .SENSE_W(SENSE_W), .TIME_W(TIME_W), .SOAK_CYCLES(SOAK_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [27:0] m;
    logic [6:0]  th1;
    logic [6:0]  th2;
    logic [6:0]  wt;
    logic [3:0]  exp_valve;
    int          exp_dur;
  } vec_t;

  typedef struct {
    logic [3:0] valve;
    int         dur;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   on_cnt = 0;
  logic [3:0] seen_valve = 4'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] mz(input logic [6:0] z0, input logic [6:0] z1,
                                     input logic [6:0] z2, input logic [6:0] z3);
    return {z3, z2, z1, z0};
  endfunction

  // Valve monitor: invariants every cycle, on-time measurement, scoreboard pop on zone_done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      on_cnt = 0;
    end else begin
      check("valve_onehot", int'($countones(bus.valve) <= 1), 1);
      check("valve_only_in_water", int'((bus.valve == 4'b0) || (bus.state == 2'b10)), 1);
      check("toggle_is_or", int'(bus.water_toggle), int'(|bus.valve));
      if (bus.valve != 4'b0) begin
        on_cnt++;
        seen_valve = bus.valve;
      end
      if (bus.zone_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_zone_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_valve", int'(seen_valve), int'(e.valve));
          check("done_duration", on_cnt, e.dur);
        end
        on_cnt = 0;
      end
      if (bus.state == 2'b00) on_cnt = 0;
    end
  end

  // Hold reset across an edge, load the scenario, release on a falling edge.
  task automatic start(input logic [27:0] m, input logic [6:0] th1,
                       input logic [6:0] th2, input logic [6:0] wt);
    @(negedge clk);
    reset = 1'b1;
    bus.m_sense = m;
    bus.m_thresh_1 = th1;
    bus.m_thresh_2 = th2;
    bus.water_time_in = wt;
    bus.l_sense = 7'd60;
    bus.l_thresh = 7'd60;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valve(input int budget, input string name);
    int k = 0;
    while (bus.valve == 4'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(bus.valve != 4'b0), 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.zone_done && k < budget);
    check(name, int'(bus.zone_done), 1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int zi;
    bus.m_sense = mz(7'd127, 7'd127, 7'd127, 7'd127);
    bus.m_thresh_1 = 7'd100;
    bus.m_thresh_2 = 7'd50;
    bus.water_time_in = 7'd50;
    bus.l_sense = 7'd60;
    bus.l_thresh = 7'd60;

    // m (z0..z3), th1, th2, wt, expected valve, expected on-time
    vecs[0]  = '{mz(7'd127, 7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd50,  4'b0000, 0};
    vecs[1]  = '{mz(7'd127, 7'd127, 7'd75,  7'd127), 7'd100, 7'd50, 7'd50,  4'b0100, 50};
    vecs[2]  = '{mz(7'd127, 7'd30,  7'd127, 7'd127), 7'd100, 7'd50, 7'd50,  4'b0010, 100};
    vecs[3]  = '{mz(7'd50,  7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd50,  4'b0001, 50};
    vecs[4]  = '{mz(7'd127, 7'd127, 7'd127, 7'd49),  7'd100, 7'd50, 7'd50,  4'b1000, 100};
    vecs[5]  = '{mz(7'd127, 7'd100, 7'd127, 7'd99),  7'd100, 7'd50, 7'd50,  4'b1000, 50};
    vecs[6]  = '{mz(7'd127, 7'd127, 7'd60,  7'd127), 7'd40,  7'd80, 7'd10,  4'b0100, 1};
    vecs[7]  = '{mz(7'd0,   7'd0,   7'd0,   7'd0),   7'd100, 7'd50, 7'd0,   4'b0000, 0};
    vecs[8]  = '{mz(7'd0,   7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd127, 4'b0001, 254};
    vecs[9]  = '{mz(7'd127, 7'd127, 7'd127, 7'd10),  7'd100, 7'd50, 7'd1,   4'b1000, 2};
    vecs[10] = '{mz(7'd75,  7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd1,   4'b0001, 1};

    // Reset values while reset is held from time zero.
    #2;
    check("rst_state", int'(bus.state), 0);
    check("rst_valve", int'(bus.valve), 0);
    check("rst_toggle", int'(bus.water_toggle), 0);
    check("rst_zone", int'(bus.active_zone), 0);
    check("rst_done", int'(bus.zone_done), 0);

    for (int i = 0; i < 11; i++) begin
      start(vecs[i].m, vecs[i].th1, vecs[i].th2, vecs[i].wt);
      if (vecs[i].exp_valve == 4'b0000) begin
        // Nothing to water: the pointer sweeps 0,1,2,3,0,... with valves shut.
        for (int k = 1; k <= 10; k++) begin
          @(negedge clk);
          check("sweep_state", int'(bus.state), 1);
          check("sweep_zone", int'(bus.active_zone), (k - 1) % ZONES);
          check("sweep_valve", int'(bus.valve), 0);
        end
      end else begin
        zi = 0;
        for (int z = 0; z < ZONES; z++) if (vecs[i].exp_valve[z]) zi = z;
        sb_q.push_back('{vecs[i].exp_valve, vecs[i].exp_dur});
        wait_done(vecs[i].exp_dur + 40, "zone_done_seen");
        check("soak_entry", int'(bus.state), 3);
        for (int k = 1; k < SOAK_CYCLES; k++) begin
          @(negedge clk);
          check("soak_hold", int'(bus.state), 3);
          check("done_single_pulse", int'(bus.zone_done), 0);
        end
        @(negedge clk);
        check("after_soak_state", int'(bus.state), 1);
        check("after_soak_zone", int'(bus.active_zone), (zi + 1) % ZONES);
      end
    end

    // Early stop: zone 0 becomes moist in the 10th watering cycle.
    start(mz(7'd30, 7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd50);
    sb_q.push_back('{4'b0001, 10});
    wait_valve(20, "early_valve_open");
    repeat (9) @(negedge clk);
    bus.m_sense = mz(7'd127, 7'd127, 7'd127, 7'd127);
    @(negedge clk);
    check("early_valve", int'(bus.valve), 0);
    check("early_done", int'(bus.zone_done), 1);
    check("early_state", int'(bus.state), 3);

    // Light abort in the 5th watering cycle, then full rewatering of zone 0.
    start(mz(7'd75, 7'd127, 7'd127, 7'd127), 7'd100, 7'd50, 7'd20);
    wait_valve(20, "abort_valve_open");
    repeat (4) @(negedge clk);
    bus.l_sense = 7'd61;
    @(negedge clk);
    check("abort_state", int'(bus.state), 0);
    check("abort_valve", int'(bus.valve), 0);
    check("abort_done", int'(bus.zone_done), 0);
    check("abort_zone", int'(bus.active_zone), 0);
    sb_q.push_back('{4'b0001, 20});
    bus.l_sense = 7'd60;
    wait_done(60, "rewater_done_seen");

    // Reset mid-watering acts without waiting for a clock edge.
    start(mz(7'd127, 7'd127, 7'd75, 7'd127), 7'd100, 7'd50, 7'd50);
    wait_valve(20, "rst_valve_open");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valve", int'(bus.valve), 0);
    check("async_rst_toggle", int'(bus.water_toggle), 0);
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_zone", int'(bus.active_zone), 0);
    check("async_rst_done", int'(bus.zone_done), 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
